// File: rtl/instr_loader_if.sv
// Byte-stream link plus instruction-memory write port and core control of the boot loader.
// slave is the loader side; master is the host/memory/core side.
interface instr_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  start;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, we, waddr, wdata, cpu_hold, done, error
    );

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, we, waddr, wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/instr_loader.sv
// Boot loader: parses <len16><N words LE><xor8> from a byte stream and writes the words
// into instruction memory, holding the core in reset until a load completes cleanly.
module instr_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 512
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_loader_if.slave  bus
);
    localparam int IDXW = $clog2(MEM_SIZE) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [IDXW-1:0]       word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [7:0]            csum_q, csum_d;
    logic [23:0]           word_buf_q, word_buf_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic        byte_ready;
    logic        accept;
    logic [15:0] len_n;
    logic        len_bad;
    logic        last_word;

    assign byte_ready = (state_q != S_IDLE);
    assign accept     = bus.byte_valid && byte_ready;
    assign len_n      = {bus.byte_in, len_q[7:0]};
    assign len_bad    = (len_n == 16'd0) || (32'(len_n) > 32'(MEM_SIZE));
    assign last_word  = (16'(word_idx_q) == len_q - 16'd1);

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
            word_buf_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            csum_q     <= csum_d;
            word_buf_q <= word_buf_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_LEN0;
            S_LEN0: if (accept) state_d = S_LEN1;
            S_LEN1: if (accept) state_d = len_bad ? S_IDLE : S_DATA;
            S_DATA: if (accept && byte_idx_q == 2'd3 && last_word) state_d = S_CSUM;
            S_CSUM: if (accept) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        csum_d     = csum_q;
        word_buf_d = word_buf_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = 1'b0;
        error_d    = error_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    error_d    = 1'b0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    csum_d     = '0;
                    cpu_hold_d = 1'b1;
                end
            end
            S_LEN0: if (accept) len_d[7:0] = bus.byte_in;
            S_LEN1: begin
                if (accept) begin
                    len_d = len_n;
                    // a rejected header leaves the core held, same as a bad checksum
                    if (len_bad) error_d = 1'b1;
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d     = csum_q ^ bus.byte_in;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_buf_d[7:0]   = bus.byte_in;
                        2'd1: word_buf_d[15:8]  = bus.byte_in;
                        2'd2: word_buf_d[23:16] = bus.byte_in;
                        default: begin
                            we_d       = 1'b1;
                            waddr_d    = ADDR_WIDTH'({word_idx_q, 2'b00});
                            wdata_d    = DATA_WIDTH'({bus.byte_in, word_buf_q});
                            word_idx_d = word_idx_q + 1'b1;
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (bus.byte_in == csum_q) begin
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.byte_ready = byte_ready;
    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: good/bad loads, backpressure, mid-load reset, full memory.
module tb_instr_loader;
    logic clk;
    logic rst_n;

    instr_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    instr_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(512)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // write/done monitor, sampled on the falling edge
    logic [31:0] wa [0:1023];
    logic [31:0] wd [0:1023];
    int nw, nd, ndbl;
    logic we_prev;

    always @(negedge clk) begin
        if (bus.we) begin
            if (nw < 1024) begin
                wa[nw] = bus.waddr;
                wd[nw] = bus.wdata;
            end
            nw = nw + 1;
            if (we_prev) ndbl = ndbl + 1;
        end
        we_prev = bus.we;
        if (bus.done) nd = nd + 1;
    end

    task automatic clr_mon();
        nw = 0;
        nd = 0;
        ndbl = 0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.byte_ready) chk("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic gap(input int n);
        bus.byte_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // 02 00 | 13 00 00 00 | 93 00 10 00 | csum
    task automatic send_prog(input logic [7:0] csum, input int gmax, input bit mid_start);
        logic [7:0] s [0:10];
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
        s[10] = csum;
        for (int i = 0; i < 11; i++) begin
            if (gmax > 0) gap($urandom_range(0, gmax));
            if (mid_start && i == 7) begin
                bus.byte_valid = 1'b0;
                pulse_start();
            end
            send_byte(s[i]);
        end
        gap(3);
    endtask

    task automatic chk_good(input string t);
        chk({t, "_nw"},    nw, 2);
        chk({t, "_a0"},    wa[0], 32'h0);
        chk({t, "_d0"},    wd[0], 32'h0000_0013);
        chk({t, "_a1"},    wa[1], 32'h4);
        chk({t, "_d1"},    wd[1], 32'h0010_0093);
        chk({t, "_done"},  nd, 1);
        chk({t, "_hold"},  32'(bus.cpu_hold), 0);
        chk({t, "_err"},   32'(bus.error), 0);
        chk({t, "_rdy"},   32'(bus.byte_ready), 0);
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  x;
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        clr_mon();
        we_prev = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_rdy",   32'(bus.byte_ready), 0);
        chk("rst_we",    32'(bus.we), 0);
        chk("rst_waddr", bus.waddr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_hold",  32'(bus.cpu_hold), 0);
        chk("rst_done",  32'(bus.done), 0);
        chk("rst_err",   32'(bus.error), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // bytes offered in IDLE are not consumed
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'hAA;
        repeat (2) @(negedge clk);
        chk("idle_rdy", 32'(bus.byte_ready), 0);
        bus.byte_valid = 1'b0;

        // good load
        clr_mon();
        pulse_start();
        chk("start_hold", 32'(bus.cpu_hold), 1);
        send_prog(8'h90, 0, 1'b0);
        chk_good("good");
        chk("good_dbl", ndbl, 0);

        // bad checksum
        clr_mon();
        pulse_start();
        send_prog(8'h91, 0, 1'b0);
        chk("bcs_nw",   nw, 2);
        chk("bcs_d1",   wd[1], 32'h0010_0093);
        chk("bcs_done", nd, 0);
        chk("bcs_err",  32'(bus.error), 1);
        chk("bcs_hold", 32'(bus.cpu_hold), 1);

        // bad length 0
        clr_mon();
        pulse_start();
        chk("bl0_errclr", 32'(bus.error), 0);
        send_byte(8'h00);
        send_byte(8'h00);
        gap(3);
        chk("bl0_err",  32'(bus.error), 1);
        chk("bl0_hold", 32'(bus.cpu_hold), 1);
        chk("bl0_nw",   nw, 0);
        chk("bl0_rdy",  32'(bus.byte_ready), 0);

        // bad length 513
        clr_mon();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h02);
        gap(3);
        chk("bl513_err", 32'(bus.error), 1);
        chk("bl513_nw",  nw, 0);

        // recovery after error
        clr_mon();
        pulse_start();
        chk("rec_errclr", 32'(bus.error), 0);
        send_prog(8'h90, 0, 1'b0);
        chk_good("rec");

        // backpressure gaps plus a start pulse mid-DATA
        clr_mon();
        pulse_start();
        send_prog(8'h90, 3, 1'b1);
        chk_good("bp");

        // reset mid-load after the 5th byte
        clr_mon();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h00);
        bus.byte_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_rdy",   32'(bus.byte_ready), 0);
        chk("mrst_we",    32'(bus.we), 0);
        chk("mrst_waddr", bus.waddr, 0);
        chk("mrst_wdata", bus.wdata, 0);
        chk("mrst_hold",  32'(bus.cpu_hold), 0);
        chk("mrst_done",  32'(bus.done), 0);
        chk("mrst_err",   32'(bus.error), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clr_mon();
        pulse_start();
        send_prog(8'h90, 0, 1'b0);
        chk_good("post_rst");

        // full memory, N = 512
        clr_mon();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        x = 8'h00;
        for (int i = 0; i < 512; i++) begin
            w = {i[7:0] ^ 8'hA5, i[15:8], 8'h5A, i[7:0]};
            for (int k = 0; k < 4; k++) begin
                x = x ^ w[8*k +: 8];
                send_byte(w[8*k +: 8]);
            end
        end
        send_byte(x);
        gap(3);
        chk("full_nw",    nw, 512);
        chk("full_a1",    wa[1], 32'h4);
        chk("full_d1",    wd[1], 32'hA4_00_5A_01);
        chk("full_alast", wa[511], 32'h7FC);
        chk("full_dlast", wd[511], 32'h5A_01_5A_FF);
        chk("full_done",  nd, 1);
        chk("full_hold",  32'(bus.cpu_hold), 0);
        chk("full_err",   32'(bus.error), 0);
        chk("full_dbl",   ndbl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader that receives a byte stream (length header, program words, checksum) and writes 32-bit instructions into the instruction memory's write port. It holds the core in reset while a load is in progress. It sits between the host byte link (UART receiver or debug bridge) and the instruction memory, on the write side of the memory that the fetch stage reads.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width; must be 32.
- ADDR_WIDTH, 32, width of `waddr` (byte address).
- MEM_SIZE, 512, instruction memory depth in words; maximum accepted word count.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- byte_in  in  8  stream data.
- byte_valid  in  1  `byte_in` is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- we  out  1  instruction memory write enable, one-cycle pulse per word.
- waddr  out  ADDR_WIDTH  byte address of the word write, always word aligned.
- wdata  out  DATA_WIDTH  word to write.
- cpu_hold  out  1  holds the core in reset while loading or after a failed load.
- done  out  1  one-cycle pulse on a successful load.
- error  out  1  sticky; set on a bad length or checksum; cleared by the next accepted `start`.

## Operation
- Handshake: a byte transfers on any cycle with `byte_valid && byte_ready`. Bytes offered while `byte_ready` is 0 are not consumed.
- States: IDLE, LEN0, LEN1, DATA, CSUM.
- IDLE: `byte_ready` is 0. On `start`:
  - clear `error`, word index, byte index and running XOR;
  - set `cpu_hold` to 1;
  - go to LEN0.
- LEN0 / LEN1: accept count low byte, then high byte, giving a 16-bit N.
  - After LEN1, N == 0 or N > MEM_SIZE: set `error`, keep `cpu_hold` at 1, go to IDLE, perform no writes.
  - Otherwise go to DATA.
- DATA: bytes are assembled little-endian (first byte goes to bits [7:0]).
  - Every data byte is XORed into an 8-bit running checksum. Header bytes are not included.
  - On the 4th byte of a word: register `we`=1, `waddr` = word_idx×4 (zero-extended), and `wdata` = the assembled word; then increment word_idx.
  - After the 4th byte of word N−1, go to CSUM.
- CSUM: accept one byte, then go to IDLE.
  - Byte equals the running XOR: pulse `done` and drop `cpu_hold`.
  - Otherwise: set `error` and keep `cpu_hold` at 1. Words already written stay in memory.
- `byte_ready` is 1 in LEN0, LEN1, DATA and CSUM.
- `start` outside IDLE is ignored.
- Widths: word_idx is clog2(MEM_SIZE)+1 bits; byte index is 2 bits and wraps 3→0.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE.
  - Outputs: `byte_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `cpu_hold`=0, `done`=0, `error`=0.
  - Internal: counters and checksum are 0.
  - Reset mid-load abandons the load; partially written words remain in memory.
- `we`/`waddr`/`wdata` are registered: the write occurs the cycle after the 4th byte is accepted. `we` is never high for two consecutive cycles.
- Back-to-back bytes are supported at one per cycle with no stalls. The write of the last word and acceptance of the checksum byte may occur in the same cycle.
- `done`, the `cpu_hold` fall and the `error` rise are all registered: they appear the cycle after the deciding byte is accepted. `done` lasts exactly one cycle.
- `cpu_hold` rises the cycle after `start` is accepted in IDLE.
- `byte_ready` falls the cycle after the CSUM or LEN1-error byte is accepted.
- Minimum load time: 2 + 4N + 1 accepted bytes, plus 1 cycle to `done`.

## Test plan
- Good load: start; send 02 00, 13 00 00 00, 93 00 10 00, 90.
  - Required: we@waddr 0x0 wdata 0x00000013; we@waddr 0x4 wdata 0x00100093; then one `done` pulse, `cpu_hold`=0, `error`=0.
- Bad checksum: same stream with final byte 91.
  - Required: both writes occur, no `done`, `error`=1, `cpu_hold` stays 1.
- Bad length: header 00 00 → `error`=1, no `we`. Header 01 02 (513) → `error`=1, no `we`. The next start with a valid stream clears `error` and succeeds.
- Backpressure/ignore: repeat the good load with `byte_valid` low 0–3 random cycles between bytes, and `start` pulsed mid-DATA.
  - Required: writes and `done` identical to the good load; the mid-load `start` has no effect.
- Reset mid-load: assert `rst_n`=0 after the 5th byte.
  - Required: all outputs 0 immediately.
  - Then a fresh good load starts writing at `waddr` 0x0.
- Full memory: N=512 (00 02), 2048 data bytes, correct XOR.
  - Required: 512 `we` pulses; last `waddr`=0x7FC; then `done`.
